// File: rtl/led_pattern_sched.sv
// Round-robin time-share of one LED between N_REQ pattern requesters.
// Plays the granted pattern MSB-first at a prescaled bit rate, then idles for a gap before releasing.
module led_pattern_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned PAT_W      = 16,
  parameter int unsigned TICK_DIV   = 16000,
  parameter int unsigned STEP_TICKS = 100,
  parameter int unsigned GAP_STEPS  = 2,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*PAT_W-1:0] pattern,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   LED,
  output logic                   PIN_14
);

  localparam int unsigned SEL_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STEP_W  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int unsigned SEG_MAX = (PAT_W > GAP_STEPS) ? PAT_W : GAP_STEPS;
  localparam int unsigned SEG_W   = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;
  localparam int unsigned REST_W  = PAT_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d, rr_q, rr_d, arb_sel, sel_inc;
  logic [REST_W-1:0]  rest_q, rest_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [N_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic               busy_q, busy_d, led_q, led_d;
  logic               arb_found, tick, step_last, bit_end, req_held;
  logic [PAT_W-1:0]   pat_sel;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
    onehot = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      if (s == SEL_W'(i)) onehot[i] = 1'b1;
  endfunction

  // First requesting index at or after the rr pointer, with wrap
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    pat_sel   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!arb_found && req[j] &&
            ((32'(rr_q) + i == j) || (32'(rr_q) + i == j + N_REQ))) begin
          arb_found = 1'b1;
          arb_sel   = SEL_W'(j);
          pat_sel   = pattern[j*PAT_W +: PAT_W];
        end
      end
    end
  end

  assign tick      = (pre_q == PRE_W'(TICK_DIV - 1));
  assign step_last = (step_q == STEP_W'(STEP_TICKS - 1));
  assign bit_end   = tick && step_last;
  assign req_held  = |(req & grant_q);
  assign sel_inc   = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + SEL_W'(1);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      rest_q  <= '0;
      pre_q   <= '0;
      step_q  <= '0;
      seg_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      rest_q  <= rest_d;
      pre_q   <= pre_d;
      step_q  <= step_d;
      seg_q   <= seg_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    rest_d  = rest_q;
    pre_d   = pre_q;
    step_d  = step_q;
    seg_d   = seg_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    led_d   = led_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_PLAY;
          sel_d   = arb_sel;
          grant_d = onehot(arb_sel);
          busy_d  = 1'b1;
          rest_d  = pat_sel[REST_W-1:0];
          led_d   = pat_sel[PAT_W-1];
          pre_d   = '0;
          step_d  = '0;
          seg_d   = '0;
        end
      end
      S_PLAY, S_GAP: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (tick) step_d = step_last ? '0 : step_q + STEP_W'(1);
        // A dropped request wins over every bit-end action, including completion
        if (!req_held) begin
          state_d = S_IDLE;
          led_d   = IDLE_LEVEL;
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = sel_inc;
        end else if (bit_end) begin
          if (state_q == S_PLAY && seg_q != SEG_W'(PAT_W - 1)) begin
            led_d  = rest_q[REST_W-1];
            rest_d = rest_q << 1;
            seg_d  = seg_q + SEG_W'(1);
          end else if (state_q == S_PLAY && GAP_STEPS != 0) begin
            state_d = S_GAP;
            led_d   = IDLE_LEVEL;
            seg_d   = '0;
          end else if (state_q == S_GAP && seg_q != SEG_W'(GAP_STEPS - 1)) begin
            seg_d = seg_q + SEG_W'(1);
          end else begin
            state_d = S_IDLE;
            led_d   = IDLE_LEVEL;
            done_d  = onehot(sel_q);
            grant_d = '0;
            busy_d  = 1'b0;
            rr_d    = sel_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign LED    = led_q;
  assign PIN_14 = led_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Scoreboard bench for led_pattern_sched: expected output-change events (with cycle spacing)
// are queued by the stimulus thread and matched by a negedge monitor thread.
module tb_led_pattern_sched;

  localparam int unsigned N  = 3;
  localparam int unsigned PW = 4;

  logic            CLK;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*PW-1:0] pattern;
  logic [N-1:0]    grant, done;
  logic            busy, LED, PIN_14;

  led_pattern_sched #(
    .N_REQ(N), .PAT_W(PW), .TICK_DIV(2), .STEP_TICKS(2), .GAP_STEPS(1), .IDLE_LEVEL(1'b0)
  ) dut (
    .CLK(CLK), .reset(reset), .req(req), .pattern(pattern),
    .grant(grant), .done(done), .busy(busy), .LED(LED), .PIN_14(PIN_14)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic [2:0] g;
    logic [2:0] d;
    logic       b;
    logic       l;
  } snap_t;

  typedef struct packed {
    snap_t s;
    int    dt;
  } ev_t;

  ev_t   exp_q[$];
  int    n_cmp;
  int    n_bad;
  int    n_ev;
  bit    mon_en;
  snap_t prev;
  int    cyc_since;

  function automatic snap_t cur_snap();
    return snap_t'({grant, done, busy, LED});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [2:0] g, input logic [2:0] d, input logic b,
                      input logic l, input int dt);
    ev_t e;
    e.s  = snap_t'({g, d, b, l});
    e.dt = dt;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_mon();
    prev      = cur_snap();
    cyc_since = 0;
    mon_en    = 1'b1;
  endtask

  task automatic stop_mon(input string nm);
    mon_en = 1'b0;
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic set_pat(input int i, input logic [PW-1:0] v);
    pattern[i*PW +: PW] = v;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_grant"}, 32'(grant), 32'd0);
    chk({nm, "_done"},  32'(done),  32'd0);
    chk({nm, "_busy"},  32'(busy),  32'd0);
    chk({nm, "_led"},   32'(LED),   32'd0);
    chk({nm, "_pin14"}, 32'(PIN_14), 32'd0);
  endtask

  // Every change of {grant,done,busy,LED} must match the next queued event and its spacing
  task automatic monitor();
    snap_t c;
    ev_t   e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        cyc_since++;
        c = cur_snap();
        if (c != prev) begin
          n_ev++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event%0d: got g=%b d=%b b=%b led=%b dt=%0d, none queued",
                     n_ev, c.g, c.d, c.b, c.l, cyc_since);
          end else begin
            e = exp_q.pop_front();
            if (e.s != c || e.dt != cyc_since || PIN_14 !== LED) begin
              n_bad++;
              $display("FAIL event%0d: got g=%b d=%b b=%b led=%b pin=%b dt=%0d, want g=%b d=%b b=%b led=%b dt=%0d",
                       n_ev, c.g, c.d, c.b, c.l, PIN_14, cyc_since, e.s.g, e.s.d, e.s.b, e.s.l, e.dt);
            end
          end
          prev      = c;
          cyc_since = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step(2);
    #2 reset = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_ev = 0; mon_en = 1'b0; cyc_since = 0;
    prev = '0;
    reset = 1'b1; req = '0; pattern = '0;
    fork
      monitor();
    join_none

    // Reset asserted before the first edge: outputs already at reset values
    #2 chk_reset_outs("reset_initial");
    @(posedge CLK); @(posedge CLK);
    #3 reset = 1'b0;
    @(posedge CLK); #1;

    // Nothing moves with no requests
    start_mon();
    step(5);
    stop_mon("idle_hold");
    chk_reset_outs("idle_after");

    // Single play of 1011
    push(3'b001, 3'b000, 1'b1, 1'b1, 2);
    push(3'b001, 3'b000, 1'b1, 1'b0, 4);
    push(3'b001, 3'b000, 1'b1, 1'b1, 4);
    push(3'b001, 3'b000, 1'b1, 1'b0, 8);
    push(3'b000, 3'b001, 1'b0, 1'b0, 4);
    push(3'b000, 3'b000, 1'b0, 1'b0, 1);
    set_pat(0, 4'b1011); req = 3'b001;
    start_mon();
    step(21); req = 3'b000;
    step(3);
    stop_mon("single");

    // Round-robin 001 -> 100 -> 001, then req0 dropped (abort) with 1,2 pending -> 010
    do_reset();
    push(3'b001, 3'b000, 1'b1, 1'b1, 2);
    push(3'b001, 3'b000, 1'b1, 1'b0, 8);
    push(3'b000, 3'b001, 1'b0, 1'b0, 12);
    push(3'b100, 3'b000, 1'b1, 1'b0, 1);
    push(3'b100, 3'b000, 1'b1, 1'b1, 4);
    push(3'b100, 3'b000, 1'b1, 1'b0, 8);
    push(3'b000, 3'b100, 1'b0, 1'b0, 8);
    push(3'b001, 3'b000, 1'b1, 1'b1, 1);
    push(3'b000, 3'b000, 1'b0, 1'b0, 1);
    push(3'b010, 3'b000, 1'b1, 1'b1, 1);
    push(3'b010, 3'b000, 1'b1, 1'b0, 4);
    push(3'b010, 3'b000, 1'b1, 1'b1, 8);
    push(3'b010, 3'b000, 1'b1, 1'b0, 4);
    push(3'b000, 3'b010, 1'b0, 1'b0, 4);
    push(3'b000, 3'b000, 1'b0, 1'b0, 1);
    set_pat(0, 4'b1100); set_pat(1, 4'b1001); set_pat(2, 4'b0110);
    req = 3'b101;
    start_mon();
    step(43); req = 3'b110;
    step(22); req = 3'b000;
    step(3);
    stop_mon("round_robin");

    // Abort on cycle 6 of play; pending requester 1 granted one edge later
    push(3'b001, 3'b000, 1'b1, 1'b1, 2);
    push(3'b001, 3'b000, 1'b1, 1'b0, 4);
    push(3'b000, 3'b000, 1'b0, 1'b0, 2);
    push(3'b010, 3'b000, 1'b1, 1'b0, 1);
    push(3'b010, 3'b000, 1'b1, 1'b1, 4);
    push(3'b010, 3'b000, 1'b1, 1'b0, 4);
    push(3'b010, 3'b000, 1'b1, 1'b1, 4);
    push(3'b010, 3'b000, 1'b1, 1'b0, 4);
    push(3'b000, 3'b010, 1'b0, 1'b0, 4);
    push(3'b000, 3'b000, 1'b0, 1'b0, 1);
    set_pat(0, 4'b1010); set_pat(1, 4'b0101);
    req = 3'b011;
    start_mon();
    step(6); req = 3'b010;
    step(22); req = 3'b000;
    step(3);
    stop_mon("abort");

    // Pattern change after grant has no effect
    push(3'b001, 3'b000, 1'b1, 1'b1, 2);
    push(3'b001, 3'b000, 1'b1, 1'b0, 4);
    push(3'b000, 3'b001, 1'b0, 1'b0, 16);
    push(3'b000, 3'b000, 1'b0, 1'b0, 1);
    set_pat(0, 4'b1000);
    req = 3'b001;
    start_mon();
    step(2); set_pat(0, 4'b1111);
    step(19); req = 3'b000;
    step(3);
    stop_mon("pattern_change");

    // Async reset in the gap: immediate reset values, no done
    push(3'b001, 3'b000, 1'b1, 1'b1, 2);
    push(3'b001, 3'b000, 1'b1, 1'b0, 16);
    set_pat(0, 4'b1111);
    req = 3'b001;
    start_mon();
    step(18);
    stop_mon("gap_before_reset");
    #2 reset = 1'b1; req = 3'b000;
    #1 chk_reset_outs("reset_in_gap");
    step(3);
    chk_reset_outs("reset_held");
    #2 reset = 1'b0;
    @(posedge CLK); #1;

    // After reset the rr pointer is 0 and requester 1 is the first asserted one
    push(3'b010, 3'b000, 1'b1, 1'b1, 2);
    push(3'b010, 3'b000, 1'b1, 1'b0, 8);
    push(3'b000, 3'b010, 1'b0, 1'b0, 12);
    push(3'b000, 3'b000, 1'b0, 1'b0, 1);
    set_pat(1, 4'b1100);
    req = 3'b010;
    start_mon();
    step(21); req = 3'b000;
    step(3);
    stop_mon("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_sched.md
Name: led_pattern_sched

Overview:
Time-shares the single board LED (and its mirror pin) between N_REQ requesters, such as boot status, error and heartbeat sources. Each requester presents a fixed-width on/off pattern. The block grants the LED round-robin, plays the granted pattern MSB-first at a fixed step rate from an internal prescaler, then inserts an idle gap and reports completion. It sits between the status sources and the top-level LED/PIN_14 outputs and replaces ad-hoc toggling off a divided clock.

Parameters:
N_REQ, 4, number of requesters (2..8)
PAT_W, 16, pattern length in bits
TICK_DIV, 16000, CLK cycles per tick (1 ms at 16 MHz)
STEP_TICKS, 100, ticks each pattern bit is held
GAP_STEPS, 2, bit-periods of idle level after each pattern (0 = no gap)
IDLE_LEVEL, 0, LED level when idle, in gap, or after abort

Ports:
CLK  input  1  system clock, 16 MHz; all logic on its rising edge
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  level request per requester; held high until done or abandoned
pattern  input  N_REQ*PAT_W  requester i pattern in bits [i*PAT_W +: PAT_W]; sampled only at grant
grant  output  N_REQ  one-hot owner of LED; all zero when idle
done  output  N_REQ  one-cycle pulse on bit i when requester i's pattern and gap complete
busy  output  1  high while a pattern or gap is in progress
LED  output  1  registered LED drive
PIN_14  output  1  copy of LED, same cycle

Behaviour:
- Reset (async assert, sync release): state IDLE; LED=PIN_14=IDLE_LEVEL; grant=0; done=0; busy=0; rr pointer=0; prescaler and step counters=0.
- States: IDLE, PLAY, GAP.
- IDLE: on an edge with any req bit high, select the first requester with req high, searching from the rr pointer upward with wrap.
  - Same edge: grant<=onehot(sel); busy<=1; shift register<=pattern[sel]; LED<=pattern[sel][PAT_W-1]; clear counters; go to PLAY.
  - LED therefore changes one cycle after req is first sampled high.
- Bit timing: every bit lasts exactly TICK_DIV*STEP_TICKS cycles.
  - Prescaler counts 0..TICK_DIV-1 and wraps; a tick is asserted at the wrap.
  - Step counter counts ticks 0..STEP_TICKS-1.
  - At the end of a bit period, shift left and update LED with the next bit.
- PLAY to GAP/IDLE: after the last bit period ends, LED<=IDLE_LEVEL.
  - If GAP_STEPS>0, go to GAP, held for GAP_STEPS bit periods.
  - If GAP_STEPS=0, behave as if GAP ended at this edge.
- Completion edge (GAP end): done[sel]<=1 for one cycle; grant<=0; busy<=0; rr pointer<=(sel+1) mod N_REQ; go to IDLE.
  - Earliest next grant is the following edge, so the minimum one-cycle IDLE gap between patterns is always present.
- Total occupancy per pattern: (PAT_W+GAP_STEPS)*STEP_TICKS*TICK_DIV cycles.
- Abort: if req[sel] is low on any edge in PLAY or GAP, including the completion edge:
  - LED<=IDLE_LEVEL; grant<=0; busy<=0; no done pulse.
  - rr pointer<=(sel+1) mod N_REQ; go to IDLE.
- Non-preemptive: requests from other requesters during PLAY/GAP are ignored until IDLE.
- Changes to pattern after grant are ignored.
- An all-zero or all-one pattern is legal and is played normally.
- Only one bit of grant and done is ever high. done is never high while busy is high.
- Counter widths: clog2 of their terminal count, minimum 1 bit.
- Async reset mid-PLAY/GAP: outputs return to reset values immediately; no done.

Test Plan:
Bench params: N_REQ=3, PAT_W=4, TICK_DIV=2, STEP_TICKS=2, GAP_STEPS=1, IDLE_LEVEL=0, giving 4 cycles per bit and 20 cycles per pattern.
- Reset: assert reset asynchronously between edges -> LED=0, PIN_14=0, grant=000, busy=0 immediately; all hold until first req.
- Single play: req=001, pattern0=4'b1011 sampled at edge E -> from E+1: LED 1,1,1,1,0,0,0,0,1,1,1,1,1,1,1,1, then 0 for 4 cycles; done=001 exactly at edge E+20; grant=000 and busy=0 at that edge.
- Round-robin: req=101 held from reset -> grants in order 001, 100, 001, each lasting 20 cycles, with one idle cycle between them; req=110 after grant 001 -> next grant is 010.
- Abort: req0 dropped at cycle 6 of play -> at the next edge LED=0, grant=000, busy=0, no done; next pending requester is granted one edge later.
- Pattern change: pattern0 switched from 4'b1000 to 4'b1111 during play -> LED still 1 for 4 cycles then 0 for 12 cycles; done asserted normally.
- Reset mid-play: assert reset in GAP -> no done; after release with req=010, requester 1 is granted first because the rr pointer is 0 and req0 is low.
